// File: rtl/rll_key_loader.sv
// Serial key loader for an RLL-locked netlist: shifts in KEY_W key bits plus even parity, commits atomically.
// Commit lands one edge after the parity bit; the sender paces bits with key_sdi_valid_i and there is no backpressure.
module rll_key_loader #(
    parameter int KEY_W     = 32,
    parameter bit RELOAD_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_start_i,
    input  logic             key_sdi_i,
    input  logic             key_sdi_valid_i,
    output logic [KEY_W-1:0] key_out_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int CW = $clog2(KEY_W + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W:0]   shift_q, shift_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             err_q, err_d;
    logic             parity_ok;

    // Even parity over key plus parity bit: XOR of the key must equal the parity bit.
    assign parity_ok = ((^shift_q[KEY_W-1:0]) == shift_q[KEY_W]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (load_start_i) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (key_sdi_valid_i) begin
                    shift_d[cnt_q] = key_sdi_i;
                    cnt_d          = cnt_q + CW'(1);
                    if (cnt_q == CW'(KEY_W)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (parity_ok) begin
                    key_d       = shift_q[KEY_W-1:0];
                    key_valid_d = 1'b1;
                    err_d       = 1'b0;
                    state_d     = RELOAD_EN ? IDLE : LOCKED;
                end else begin
                    // A failed reload must not leave the previous key driving the netlist.
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end

    assign key_out_o   = key_q;
    assign key_valid_o = key_valid_q;
    assign busy_o      = (state_q == SHIFT) || (state_q == CHECK);
    assign err_o       = err_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: one reloadable instance and one lock-after-first-commit instance.
module tb_rll_key_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        key_sdi = 1'b0;
    logic        key_sdi_valid = 1'b0;
    logic [31:0] key_out1, key_out0;
    logic        key_valid1, key_valid0;
    logic        busy1, busy0;
    logic        err1, err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rll_key_loader #(.KEY_W(32), .RELOAD_EN(1'b1)) u_reload (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .key_sdi_i(key_sdi),
        .key_sdi_valid_i(key_sdi_valid), .key_out_o(key_out1), .key_valid_o(key_valid1),
        .busy_o(busy1), .err_o(err1)
    );

    rll_key_loader #(.KEY_W(32), .RELOAD_EN(1'b0)) u_once (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .key_sdi_i(key_sdi),
        .key_sdi_valid_i(key_sdi_valid), .key_out_o(key_out0), .key_valid_o(key_valid0),
        .busy_o(busy0), .err_o(err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start    = 1'b1;
        key_sdi_valid = 1'b0;
        tick();
        load_start    = 1'b0;
    endtask

    task automatic shift_bits(input logic [32:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            key_sdi       = v[i];
            key_sdi_valid = 1'b1;
            tick();
        end
        key_sdi_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({key_out1, key_valid1, busy1, err1} !== 35'd0) begin
            errors++;
            $display("FAIL reset_reload: got key=%h v=%b busy=%b err=%b, want all 0", key_out1, key_valid1, busy1, err1);
        end
        checks++;
        if ({key_out0, key_valid0, busy0, err0} !== 35'd0) begin
            errors++;
            $display("FAIL reset_once: got key=%h v=%b busy=%b err=%b, want all 0", key_out0, key_valid0, busy0, err0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_good_load();
        start_load();
        shift_bits({1'b0, 32'hA5C3_0F1E}, 33);
        checks++;
        if (busy1 !== 1'b1 || key_valid1 !== 1'b0 || key_out1 !== 32'h0) begin
            errors++;
            $display("FAIL good_pre_commit: got busy=%b v=%b key=%h, want busy=1 v=0 key=0", busy1, key_valid1, key_out1);
        end
        tick();
        checks++;
        if (key_out1 !== 32'hA5C3_0F1E || key_valid1 !== 1'b1 || err1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL good_commit: got key=%h v=%b err=%b busy=%b, want a5c30f1e 1 0 0", key_out1, key_valid1, err1, busy1);
        end
    endtask

    task automatic test_parity_err();
        start_load();
        shift_bits({1'b1, 32'hA5C3_0F1E}, 33);
        tick();
        checks++;
        if (key_out1 !== 32'h0 || key_valid1 !== 1'b0 || err1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_err: got key=%h v=%b err=%b busy=%b, want 0 0 1 0", key_out1, key_valid1, err1, busy1);
        end
    endtask

    task automatic test_gaps();
        logic [32:0] v;
        v = {1'b1, 32'h0000_0001};
        start_load();
        checks++;
        if (err1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL gaps_start: got err=%b busy=%b, want err=0 busy=1", err1, busy1);
        end
        for (int i = 0; i < 33; i++) begin
            repeat ($urandom_range(0, 2)) begin
                key_sdi       = 1'($urandom);
                key_sdi_valid = 1'b0;
                tick();
            end
            key_sdi       = v[i];
            key_sdi_valid = 1'b1;
            tick();
            key_sdi_valid = 1'b0;
            checks++;
            if (key_out1 !== 32'h0 || key_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL gaps_hold bit %0d: got key=%h v=%b, want 0 0", i, key_out1, key_valid1);
            end
        end
        tick();
        checks++;
        if (key_out1 !== 32'h0000_0001 || key_valid1 !== 1'b1 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL gaps_commit: got key=%h v=%b err=%b, want 00000001 1 0", key_out1, key_valid1, err1);
        end
    endtask

    task automatic test_restart();
        start_load();
        shift_bits(33'h0, 10);
        load_start    = 1'b1;
        key_sdi       = 1'b0;
        key_sdi_valid = 1'b1;
        tick();
        load_start    = 1'b0;
        key_sdi_valid = 1'b0;
        shift_bits({1'b0, 32'hFFFF_FFFF}, 33);
        tick();
        checks++;
        if (key_out1 !== 32'hFFFF_FFFF || key_valid1 !== 1'b1 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL restart: got key=%h v=%b err=%b, want ffffffff 1 0", key_out1, key_valid1, err1);
        end
    endtask

    task automatic test_no_reload();
        logic [32:0] v;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_load();
        shift_bits({1'b1, 32'h1234_5678}, 33);
        tick();
        checks++;
        if (key_out0 !== 32'h1234_5678 || key_valid0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL once_first: got key=%h v=%b busy=%b, want 12345678 1 0", key_out0, key_valid0, busy0);
        end
        start_load();
        v = 33'h0;
        for (int i = 0; i < 33; i++) begin
            key_sdi       = v[i];
            key_sdi_valid = 1'b1;
            tick();
            checks++;
            if (busy0 !== 1'b0) begin
                errors++;
                $display("FAIL once_busy bit %0d: got busy=%b, want 0", i, busy0);
            end
        end
        key_sdi_valid = 1'b0;
        tick();
        checks++;
        if (key_out0 !== 32'h1234_5678 || key_valid0 !== 1'b1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL once_hold: got key=%h v=%b err=%b, want 12345678 1 0", key_out0, key_valid0, err0);
        end
        checks++;
        if (key_out1 !== 32'h0 || key_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL reload_zero: got key=%h v=%b, want 00000000 1", key_out1, key_valid1);
        end
    endtask

    task automatic test_rst_mid();
        start_load();
        shift_bits({1'b0, 32'hA5C3_0F1E}, 20);
        rst = 1'b1;
        #1;
        checks++;
        if ({key_out1, key_valid1, busy1, err1, key_out0, key_valid0, busy0, err0} !== 70'd0) begin
            errors++;
            $display("FAIL rst_shift: got k1=%h v1=%b b1=%b k0=%h v0=%b b0=%b, want all 0", key_out1, key_valid1, busy1, key_out0, key_valid0, busy0);
        end
        tick();
        rst = 1'b0;
        start_load();
        shift_bits({1'b1, 32'h1234_5678}, 33);
        tick();
        checks++;
        if (key_out1 !== 32'h1234_5678 || key_valid1 !== 1'b1 || key_out0 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rst_shift_reload: got k1=%h v1=%b k0=%h, want 12345678 1 12345678", key_out1, key_valid1, key_out0);
        end
        start_load();
        shift_bits({1'b0, 32'hA5C3_0F1E}, 33);
        rst = 1'b1;
        #1;
        checks++;
        if ({key_out1, key_valid1, busy1, err1, key_out0, key_valid0, busy0, err0} !== 70'd0) begin
            errors++;
            $display("FAIL rst_check: got k1=%h v1=%b b1=%b k0=%h v0=%b b0=%b, want all 0", key_out1, key_valid1, busy1, key_out0, key_valid0, busy0);
        end
        tick();
        rst = 1'b0;
        start_load();
        shift_bits({1'b0, 32'hA5C3_0F1E}, 33);
        tick();
        checks++;
        if (key_out1 !== 32'hA5C3_0F1E || key_valid1 !== 1'b1 || key_out0 !== 32'hA5C3_0F1E || key_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_check_reload: got k1=%h v1=%b k0=%h v0=%b, want a5c30f1e 1 a5c30f1e 1", key_out1, key_valid1, key_out0, key_valid0);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_parity_err();
        test_gaps();
        test_restart();
        test_no_reload();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
